// File: rtl/lsu_dmem_port.sv
// Load/store adapter between an LSU request channel and a single-port, word-wide data memory.
// Define LSU_MISALIGNED_SPLIT_EN to serve boundary-crossing accesses as two word cycles (ACC1, ACC2).
module lsu_dmem_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic [3:0] f_lane_mask(input logic [1:0] size);
    case (size)
      SZ_B:    f_lane_mask = 4'b0001;
      SZ_H:    f_lane_mask = 4'b0011;
      default: f_lane_mask = 4'b1111;
    endcase
  endfunction

  // raw holds {second word, first word}; the result starts at byte offset off.
  function automatic logic [31:0] f_load(input logic [63:0] raw, input logic [1:0] off,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = 32'(raw >> {off, 3'b000});
    case (size)
      SZ_B:    f_load = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    f_load = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: f_load = sh;
    endcase
  endfunction

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;

  logic [1:0]  w_off;
  logic        w_err;
  logic [63:0] w_raw;
  logic [31:0] w_load_data;

  assign w_off = req_addr[1:0];

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        r_split;
  logic [3:0]  r_dwe_hi;
  logic [31:0] r_wdata_hi;
  logic [31:0] r_rd_lo;
  logic        w_split;
  logic [63:0] w_sdata;
  logic [7:0]  w_sbe;

  assign w_err   = (req_size == 2'b11);
  assign w_split = ((req_size == SZ_H) && (w_off == 2'b11)) ||
                   ((req_size == SZ_W) && (w_off != 2'b00));
  assign w_sdata = {32'd0, req_wdata} << {w_off, 3'b000};
  assign w_sbe   = {4'd0, f_lane_mask(req_size)} << w_off;
  assign w_raw   = (r_state == ACC2) ? {drdata, r_rd_lo} : {32'd0, drdata};
`else
  logic [31:0] w_sdata;
  logic [3:0]  w_sbe;

  // Anything that would straddle a word boundary or sit at an odd halfword address is refused.
  assign w_err   = (req_size == 2'b11) ||
                   ((req_size == SZ_H) && w_off[0]) ||
                   ((req_size == SZ_W) && (w_off != 2'b00));
  assign w_sdata = req_wdata << {w_off, 3'b000};
  assign w_sbe   = f_lane_mask(req_size) << w_off;
  assign w_raw   = {32'd0, drdata};
`endif

  assign w_load_data = r_we ? 32'd0 : f_load(w_raw, r_off, r_size, r_uns);

  // Request sequencing and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      daddr      <= 32'd0;
      dwdata     <= 32'd0;
      dwe        <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_uns      <= 1'b0;
      r_off      <= 2'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split    <= 1'b0;
      r_dwe_hi   <= 4'd0;
      r_wdata_hi <= 32'd0;
      r_rd_lo    <= 32'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          if (req_valid) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_uns     <= req_unsigned;
            r_off     <= w_off;
            req_ready <= 1'b0;
            if (w_err) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              daddr      <= 32'd0;
              dwdata     <= 32'd0;
              dwe        <= 4'd0;
            end else begin
              r_state <= ACC1;
              daddr   <= {req_addr[31:2], 2'b00};
              dwdata  <= req_we ? w_sdata[31:0] : 32'd0;
              dwe     <= req_we ? w_sbe[3:0] : 4'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
              r_split    <= w_split;
              r_dwe_hi   <= req_we ? w_sbe[7:4] : 4'd0;
              r_wdata_hi <= req_we ? w_sdata[63:32] : 32'd0;
`endif
            end
          end else begin
            req_ready <= 1'b1;
            daddr     <= 32'd0;
            dwdata    <= 32'd0;
            dwe       <= 4'd0;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ACC1: begin
          if (r_split) begin
            r_state <= ACC2;
            daddr   <= daddr + 32'd4;
            dwdata  <= r_wdata_hi;
            dwe     <= r_dwe_hi;
            r_rd_lo <= drdata;
          end else begin
            r_state    <= RESP;
            daddr      <= 32'd0;
            dwdata     <= 32'd0;
            dwe        <= 4'd0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= w_load_data;
          end
        end
        ACC2: begin
          r_state    <= RESP;
          daddr      <= 32'd0;
          dwdata     <= 32'd0;
          dwe        <= 4'd0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= w_load_data;
        end
`else
        ACC1: begin
          r_state    <= RESP;
          daddr      <= 32'd0;
          dwdata     <= 32'd0;
          dwe        <= 4'd0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= w_load_data;
        end
`endif
        default: begin
          r_state    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          daddr      <= 32'd0;
          dwdata     <= 32'd0;
          dwe        <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_dmem_port.md
LSU_DMEM_PORT -- requirements
Module: lsu_dmem_port

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock shared with the data memory.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1 bit: the request is valid.
REQ-004 SHALL have port req_ready, output, 1 bit: the block accepts a request.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word (11 reserved, reported as an error).
REQ-007 SHALL have port req_unsigned, input, 1 bit: zero-extend the load result.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: extended load data (0 for stores).
REQ-012 SHALL have port resp_err, output, 1 bit: access rejected, valid with resp_valid.
REQ-013 SHALL have port daddr, output, 32 bits: word-aligned memory address (bits 1:0 = 0).
REQ-014 SHALL have port dwdata, output, 32 bits: lane-positioned store data.
REQ-015 SHALL have port dwe, output, 4 bits: byte-lane write enables; bit n drives byte n.
REQ-016 SHALL have port drdata, input, 32 bits: combinational memory read of daddr.

Function
REQ-017 SHALL implement FSM states IDLE, ACC1, ACC2, RESP.
REQ-018 SHALL assert req_ready only in IDLE, and SHALL register the request when req_valid and req_ready are both high.
REQ-019 SHALL, on acceptance at edge N, drive ACC1 during cycle N+1 and assert resp_valid during cycle N+2 when the access needs one word.
REQ-020 SHALL, in ACC1, set daddr = {addr[31:2],2'b00}; SHALL, in ACC2, set daddr = ACC1 address + 4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-021 SHALL hold daddr, dwdata and dwe at 0 in IDLE and RESP.
REQ-022 SHALL, for stores, shift data left by 8*addr[1:0] and set dwe to 0001, 0011 or 1111 shifted by addr[1:0], with bits beyond lane 3 carried into ACC2's low lanes.
REQ-023 SHALL, for loads, capture drdata at the end of each ACC cycle, then select bytes from the concatenation {ACC2 word, ACC1 word} starting at byte offset addr[1:0].
REQ-024 SHALL sign-extend byte and half loads from bit 7 or bit 15 respectively, or zero-extend them when req_unsigned is set; word loads SHALL pass through unchanged.
REQ-025 SHALL treat half at offset 3 and word at offset 1, 2 or 3 as boundary-crossing accesses, which need ACC2.
REQ-026 SHALL treat half at offset 1 as misaligned but within a single word.
REQ-027 SHALL, for req_size = 11, skip both ACC states, go straight to RESP, assert resp_err = 1, and write nothing.
REQ-028 SHALL hold resp_rdata, resp_err and resp_valid at 0 except during RESP.
REQ-029 SHALL return from RESP to IDLE; the earliest next acceptance is the cycle after RESP.
REQ-030 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-031 SHALL, while reset is high, immediately force state IDLE and set req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, daddr=0, dwdata=0, dwe=0.
REQ-032 SHALL, on reset asserted during ACC1 or ACC2, drop dwe asynchronously, produce no response, and perform no ACC2 write after reset releases.

Configuration
REQ-033 SHALL, with LSU_MISALIGNED_SPLIT_EN defined, perform boundary-crossing accesses as ACC1 then ACC2, with resp_valid at N+3, and serve offset-1 halfwords in one access.
REQ-034 SHALL, without LSU_MISALIGNED_SPLIT_EN, treat any half with addr[0]=1 and any word with addr[1:0]!=0 as an error: no ACC states, dwe stays 0, resp_valid at N+1 with resp_err=1, and ACC2 logic absent.

Verification
REQ-035 SHALL check: SW addr 0x10, data 0xDEADBEEF -> ACC1 daddr=0x10, dwe=1111, dwdata=0xDEADBEEF; resp_valid at N+2 with resp_err=0.
REQ-036 SHALL check: SB addr 0x13, data 0x000000A5 -> dwe=1000, dwdata=0xA5000000; then LB 0x13 -> resp_rdata=0xFFFFFFA5 and LBU 0x13 -> 0x000000A5.
REQ-037 SHALL check: LH addr 0x22 with word 0x80017F00 at 0x20 -> resp_rdata=0xFFFF8001; the same access with LHU -> 0x00008001.
REQ-038 SHALL check: with the macro defined, SW addr 0x33, data 0x11223344 -> ACC1 daddr=0x30, dwe=1000, dwdata=0x44000000; ACC2 daddr=0x34, dwe=0111, dwdata low lanes=0x112233; then LW 0x33 -> 0x11223344 at N+3.
REQ-039 SHALL check: without the macro, LW addr 0x31 -> dwe never nonzero; resp_valid at N+1 with resp_err=1.
REQ-040 SHALL check: reset pulsed during ACC1 of a split store -> dwe=0 immediately; memory at word+4 unchanged; req_ready=1 after release.
